calc_cmd_sequencer: RTL

- Sits between the keypad front-end and the calculator core.
- Buffers key codes arriving on a valid/ready handshake in a small FIFO.
- Presents each code to the core's cmd input for exactly one clock, separated by NOP cycles. The core samples cmd on every edge, so this guarantees each key is seen once.
- Holds issue while the core reports busy, and recovers from core error by discarding queued keys up to the next CLR.

---
 rtl/calc_cmd_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/calc_cmd_sequencer.sv
// calc_cmd_sequencer
// Buffers keypad codes in a small FIFO and feeds them to the calculator core
// one at a time. Each code is shown on calc_cmd for a single clock and is
// followed by at least GAP NOP cycles. Issue stalls while the core is busy.
// On a core error, queued keys are discarded until a CLR (F) reaches the head.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   key_valid   in   key code offered by the keypad front-end
//   key_code    in   4-bit key code
//   key_ready   out  FIFO can accept (count < DEPTH)
//   calc_status in   core status: 0 ready, 1 busy, 2 error (3 treated as busy)
//   calc_cmd    out  registered command to the core, NOP_CODE when idle
//   issued      out  pulse coincident with a non-NOP calc_cmd
//   dropped     out  pulse after a queued key is discarded in error recovery
//   error_flag  out  high while holding in error recovery
//   fifo_count  out  current FIFO occupancy
module calc_cmd_sequencer #(
   parameter int         DEPTH    = 4,
   parameter int         GAP      = 1,
   parameter logic [3:0] NOP_CODE = 4'hD
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     key_valid,
   input  logic [3:0]               key_code,
   output logic                     key_ready,
   input  logic [1:0]               calc_status,
   output logic [3:0]               calc_cmd,
   output logic                     issued,
   output logic                     dropped,
   output logic                     error_flag,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   // Out-of-range GAP values are clamped into 1..7.
   localparam int GAP_EFF = (GAP < 1) ? 1 : ((GAP > 7) ? 7 : GAP);
   localparam logic [2:0]    GAP_LOAD   = 3'(GAP_EFF - 1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
   localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
   localparam logic [PW-1:0] PTR_ONE    = PW'(1);
   localparam logic [3:0]    CLR_CODE   = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ISSUE    = 2'd1,
      ST_GAP      = 2'd2,
      ST_ERR_HOLD = 2'd3
   } state_t;

   state_t          state_r;
   state_t          state_s;
   logic [2:0]      gap_cnt_r;
   logic [2:0]      gap_cnt_s;
   logic [3:0]      mem_r [DEPTH];
   logic [PW-1:0]   wr_ptr_r;
   logic [PW-1:0]   rd_ptr_r;
   logic [CW-1:0]   count_r;
   logic [3:0]      calc_cmd_r;
   logic            issued_r;
   logic            dropped_r;
   logic            error_flag_r;
   logic [3:0]      head_s;
   logic            empty_s;
   logic            push_s;
   logic            pop_s;
   logic            drop_s;

   assign head_s  = mem_r[rd_ptr_r];
   assign empty_s = (count_r == {CW{1'b0}});
   // A NOP key completes the handshake but is never stored.
   assign push_s  = key_valid && key_ready && (key_code != NOP_CODE);
   // The head leaves the FIFO at the end of its ISSUE cycle or when discarded.
   assign pop_s   = (state_r == ST_ISSUE) || drop_s;

   // Next-state and error-recovery decisions.
   always_comb begin
      state_s   = state_r;
      gap_cnt_s = gap_cnt_r;
      drop_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (calc_status == 2'd2) begin
               state_s = ST_ERR_HOLD;
            end else if (!empty_s && (calc_status == 2'd0)) begin
               state_s = ST_ISSUE;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            state_s   = ST_GAP;
            gap_cnt_s = GAP_LOAD;
         end
         ST_GAP: begin
            if (gap_cnt_r == 3'd0) begin
               state_s = ST_IDLE;
            end else begin
               gap_cnt_s = gap_cnt_r - 3'd1;
            end
         end
         ST_ERR_HOLD: begin
            // CLR at the head wins; otherwise a core that recovered on its own
            // releases us; otherwise keep discarding stale keys.
            if (!empty_s && (head_s == CLR_CODE)) begin
               state_s = ST_ISSUE;
            end else if (calc_status == 2'd0) begin
               state_s = ST_IDLE;
            end else if (!empty_s) begin
               drop_s = 1'b1;
            end else begin
               state_s = ST_ERR_HOLD;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, FIFO bookkeeping and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         gap_cnt_r    <= 3'd0;
         wr_ptr_r     <= {PW{1'b0}};
         rd_ptr_r     <= {PW{1'b0}};
         count_r      <= {CW{1'b0}};
         calc_cmd_r   <= NOP_CODE;
         issued_r     <= 1'b0;
         dropped_r    <= 1'b0;
         error_flag_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         gap_cnt_r <= gap_cnt_s;
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + COUNT_ONE;
            2'b01:   count_r <= count_r - COUNT_ONE;
            default: count_r <= count_r;
         endcase
         // The head cannot move on the edge entering ISSUE, so it is safe to
         // latch it here and show it for the whole ISSUE cycle.
         calc_cmd_r   <= (state_s == ST_ISSUE) ? head_s : NOP_CODE;
         issued_r     <= (state_s == ST_ISSUE);
         dropped_r    <= drop_s;
         error_flag_r <= (state_s == ST_ERR_HOLD);
      end
   end

   // FIFO storage; contents need no reset because the pointers define validity.
   always_ff @(posedge clock) begin
      if (push_s && !reset) begin
         mem_r[wr_ptr_r] <= key_code;
      end
   end

   assign key_ready  = (count_r < FULL_COUNT);
   assign calc_cmd   = calc_cmd_r;
   assign issued     = issued_r;
   assign dropped    = dropped_r;
   assign error_flag = error_flag_r;
   assign fifo_count = count_r;

endmodule
